// File: rtl/alu1_sched_pkg.sv
// Shared types for the ALU1 issue scheduler: command encoding, queued operation
// record, FSM state codes and the branch classifier.
package alu1_sched_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [3:0] {
    c_NOP  = 4'd0,
    c_SLT  = 4'd1,
    c_SLTU = 4'd2,
    c_BEQ  = 4'd3,
    c_BNE  = 4'd4,
    c_BLT  = 4'd5,
    c_BGE  = 4'd6,
    c_BLTU = 4'd7,
    c_BGEU = 4'd8
  } alu_commands_t;

  localparam alu_commands_t ALU_CMD_IDLE = c_NOP;

  typedef logic [2:0] alu1_sched_state_t;
  localparam alu1_sched_state_t S_IDLE  = 3'd0;
  localparam alu1_sched_state_t S_ISSUE = 3'd1;
  localparam alu1_sched_state_t S_WAIT  = 3'd2;
  localparam alu1_sched_state_t S_HOLD  = 3'd3;
  localparam alu1_sched_state_t S_FLUSH = 3'd4;

  typedef struct packed {
    logic [XLEN-1:0]       arg0;
    logic [XLEN-1:0]       arg1;
    logic [XLEN-1:0]       addr;
    logic [XLEN-1:0]       imm;
    alu_commands_t         cmd;
    logic [REG_ADDR_W-1:0] rd;
    logic                  predict;
  } alu1_op_t;

  // Only conditional branches can redirect the pipeline on a mispredict.
  function automatic logic is_branch(alu_commands_t cmd);
    case (cmd)
      c_BEQ, c_BNE, c_BLT, c_BGE, c_BLTU, c_BGEU: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu1_sched_if.sv
// Bundle of issuer, ALU1 and commiter signals around the scheduler.
// The slave modport is the scheduler's view; master is the surrounding pipeline.
interface alu1_sched_if
  import alu1_sched_pkg::*;
#(
  parameter int DEPTH = 4
) ();

  localparam int PTR_W = $clog2(DEPTH);

  logic                  enq_valid;
  logic                  enq_ready;
  logic [XLEN-1:0]       enq_arg0;
  logic [XLEN-1:0]       enq_arg1;
  logic [XLEN-1:0]       enq_addr;
  logic [XLEN-1:0]       enq_imm;
  alu_commands_t         enq_cmd;
  logic [REG_ADDR_W-1:0] enq_rd;
  logic                  enq_predict;

  logic [XLEN-1:0]       alu_arg0;
  logic [XLEN-1:0]       alu_arg1;
  logic [XLEN-1:0]       alu_addr;
  logic [XLEN-1:0]       alu_imm;
  alu_commands_t         alu_cmd;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic                  alu_predict;
  logic                  alu_valid;
  logic                  alu_error;
  logic                  alu_mispredict;
  logic                  alu_clear;

  logic                  cmt_req;
  logic                  cmt_ack;
  logic                  flush;
  logic                  err;
  logic [PTR_W:0]        count;

  modport slave (
    input  enq_valid, enq_arg0, enq_arg1, enq_addr, enq_imm, enq_cmd, enq_rd, enq_predict,
    input  alu_valid, alu_error, alu_mispredict, cmt_ack,
    output enq_ready, alu_arg0, alu_arg1, alu_addr, alu_imm, alu_cmd, alu_rd, alu_predict,
    output alu_clear, cmt_req, flush, err, count
  );

  modport master (
    output enq_valid, enq_arg0, enq_arg1, enq_addr, enq_imm, enq_cmd, enq_rd, enq_predict,
    output alu_valid, alu_error, alu_mispredict, cmt_ack,
    input  enq_ready, alu_arg0, alu_arg1, alu_addr, alu_imm, alu_cmd, alu_rd, alu_predict,
    input  alu_clear, cmt_req, flush, err, count
  );

endinterface

// File: rtl/alu1_sched_fifo.sv
// In-order queue of pending ALU1 operations with a single-cycle discard-all flush.
module alu1_sched_fifo
  import alu1_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_push,
  input  logic           i_pop,
  input  logic           i_flush,
  input  alu1_op_t       i_data,
  output logic           o_full,
  output logic           o_empty,
  output logic [PTR_W:0] o_count,
  output alu1_op_t       o_head
);

  alu1_op_t         r_mem [DEPTH];
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W:0]   r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_full   = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;
  assign o_head   = r_mem[r_rdPtr];
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two; flush beats push/pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rdPtr <= r_wrPtr;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      r_count <= r_count + {{PTR_W{1'b0}}, w_doPush} - {{PTR_W{1'b0}}, w_doPop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush && !i_flush) r_mem[r_wrPtr] <= i_data;
  end

endmodule

// File: rtl/alu1_sched.sv
// ALU1 issue scheduler: queues branch/compare ops, issues one at a time, holds the
// result for the commiter and flushes younger work on a branch mispredict.
module alu1_sched
  import alu1_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic         clk,
  input logic         rst_n,
  alu1_sched_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);

  alu1_sched_state_t r_state;
  alu1_sched_state_t w_nextState;
  alu1_op_t          r_aluOp;
  alu_commands_t     r_aluCmd;
  logic              r_mispredict;
  logic              r_err;

  alu1_op_t          w_enqOp;
  alu1_op_t          w_head;
  logic              w_full;
  logic              w_empty;
  logic [PTR_W:0]    w_count;
  logic              w_enqReady;
  logic              w_push;
  logic              w_pop;
  logic              w_ack;
  logic              w_doFlush;
  logic              w_loadOp;

  assign w_enqOp = '{arg0: bus.enq_arg0, arg1: bus.enq_arg1, addr: bus.enq_addr,
                     imm: bus.enq_imm, cmd: bus.enq_cmd, rd: bus.enq_rd,
                     predict: bus.enq_predict};

  assign w_enqReady = rst_n && !w_full && (r_state != S_FLUSH);
  assign w_push     = bus.enq_valid && w_enqReady;
  assign w_pop      = (r_state == S_ISSUE);
  assign w_ack      = (r_state == S_HOLD) && bus.cmt_ack;
  assign w_doFlush  = w_ack && r_mispredict && is_branch(r_aluOp.cmd);
  assign w_loadOp   = (w_nextState == S_ISSUE);

  alu1_sched_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_doFlush),
    .i_data  (w_enqOp),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_head  (w_head)
  );

  // A committed op goes straight to the next queued one without an IDLE bubble.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty) w_nextState = S_ISSUE;
      S_ISSUE: w_nextState = S_WAIT;
      S_WAIT:  if (bus.alu_valid) w_nextState = S_HOLD;
      S_HOLD: begin
        if (bus.cmt_ack) begin
          if (w_doFlush)     w_nextState = S_FLUSH;
          else if (!w_empty) w_nextState = S_ISSUE;
          else               w_nextState = S_IDLE;
        end
      end
      S_FLUSH: w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_aluOp      <= '0;
      r_aluCmd     <= ALU_CMD_IDLE;
      r_mispredict <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_loadOp) begin
        r_aluOp  <= w_head;
        r_aluCmd <= w_head.cmd;
      end else if (r_state == S_ISSUE) begin
        r_aluCmd <= ALU_CMD_IDLE;
      end
      if ((r_state == S_WAIT) && bus.alu_valid) begin
        r_mispredict <= bus.alu_mispredict;
        if (bus.alu_error) r_err <= 1'b1;
      end
    end
  end

  assign bus.enq_ready   = w_enqReady;
  assign bus.alu_arg0    = r_aluOp.arg0;
  assign bus.alu_arg1    = r_aluOp.arg1;
  assign bus.alu_addr    = r_aluOp.addr;
  assign bus.alu_imm     = r_aluOp.imm;
  assign bus.alu_cmd     = r_aluCmd;
  assign bus.alu_rd      = r_aluOp.rd;
  assign bus.alu_predict = r_aluOp.predict;
  assign bus.alu_clear   = w_ack;
  assign bus.cmt_req     = (r_state == S_HOLD);
  assign bus.flush       = (r_state == S_FLUSH);
  assign bus.err         = r_err;
  assign bus.count       = w_count;

endmodule
